// File: rtl/wb_host_pkg.sv
// Shared constants for the byte-stream to Wishbone host bridge: command opcodes,
// response status bytes and FSM state encodings.
package wb_host_pkg;

  // Command opcodes (first byte of a frame)
  localparam logic [7:0] OP_WR = 8'h01;
  localparam logic [7:0] OP_RD = 8'h02;

  // Single-byte status responses
  localparam logic [7:0] ST_OK  = 8'hA5;
  localparam logic [7:0] ST_TMO = 8'hEE;

  // Parser / bus FSM states
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_ADRH = 3'd1;
  localparam state_t S_ADRL = 3'd2;
  localparam state_t S_DATA = 3'd3;
  localparam state_t S_BUS  = 3'd4;
  localparam state_t S_RESP = 3'd5;

  // States in which the bridge accepts command bytes
  function automatic logic accepts_rx(input state_t s);
    return (s == S_IDLE) || (s == S_ADRH) || (s == S_ADRL) || (s == S_DATA);
  endfunction

endpackage

// File: rtl/wb_host_timeout.sv
// Bus-cycle watchdog: cleared by load, counts enabled cycles, flags expiry on the
// enabled cycle that brings the count to TIMEOUT. Used only with WB_TIMEOUT_EN.
module wb_host_timeout #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam int unsigned LIMIT = (TIMEOUT < 1) ? 1 : TIMEOUT;
  localparam int unsigned CW    = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count_q;

  // Expiry is flagged combinationally so the FSM leaves BUS on the TIMEOUT-th cycle
  assign expired = enable && (count_q == LAST);

  // Wait-cycle counter, saturating at the expiry value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= '0;
    end else if (enable && (count_q != LAST)) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/wb_host_bridge.sv
// Byte-stream to Wishbone initiator. Parses {opcode, ADR_H, ADR_L, data...} frames,
// runs one classic single Wishbone cycle per command and returns a status byte
// (write) or the read data MSB first (read).
// Optional feature macro: WB_TIMEOUT_EN adds a bus-cycle watchdog that aborts after
// TIMEOUT cycles without ack_i and answers 0xEE.
module wb_host_bridge
  import wb_host_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_dat,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [7:0]       tx_dat,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [14:0]      adr_o,
  output logic [WIDTH-1:0] dat_o,
  input  logic [WIDTH-1:0] dat_i,
  output logic             we_o,
  output logic             stb_o,
  input  logic             ack_i
);

  localparam int unsigned NB = WIDTH / 8;
  localparam logic [2:0] NB_CNT  = 3'(NB);
  localparam logic [2:0] NB_LAST = 3'(NB - 1);
  // Status bytes left-aligned so the response shifter always emits the top byte
  localparam logic [WIDTH-1:0] OK_WORD  = WIDTH'(ST_OK) << (WIDTH - 8);
  localparam logic [WIDTH-1:0] TMO_WORD = WIDTH'(ST_TMO) << (WIDTH - 8);

  state_t           state_q, state_d;
  logic             wr_q, wr_d;
  logic [14:0]      adr_q, adr_d;
  logic [WIDTH-1:0] wdat_q, wdat_d;
  logic [WIDTH-1:0] resp_q, resp_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             rx_fire, tx_fire;
  logic             in_bus;
  logic             tmo_expired;

  assign in_bus  = (state_q == S_BUS);
  // rx_ready is gated by rst so it reads 0 while reset is held
  assign rx_ready = !rst && accepts_rx(state_q);
  assign tx_valid = (state_q == S_RESP);
  assign tx_dat   = tx_valid ? resp_q[WIDTH-1 -: 8] : 8'h00;
  assign rx_fire  = rx_valid && rx_ready;
  assign tx_fire  = tx_valid && tx_ready;

  assign stb_o = in_bus;
  assign we_o  = in_bus && wr_q;
  assign adr_o = adr_q;
  assign dat_o = wdat_q;

`ifdef WB_TIMEOUT_EN
  wb_host_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .load    (!in_bus),
    .enable  (in_bus && !ack_i),
    .expired (tmo_expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign tmo_expired    = 1'b0;
`endif

  // Frame parser, bus cycle control and response sequencing
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    resp_d  = resp_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        // Unknown opcodes are consumed and dropped without a response
        if (rx_fire) begin
          if (rx_dat == OP_WR) begin
            wr_d    = 1'b1;
            state_d = S_ADRH;
          end else if (rx_dat == OP_RD) begin
            wr_d    = 1'b0;
            state_d = S_ADRH;
          end
        end
      end
      S_ADRH: begin
        if (rx_fire) begin
          adr_d[14:8] = rx_dat[6:0];
          state_d     = S_ADRL;
        end
      end
      S_ADRL: begin
        if (rx_fire) begin
          adr_d[7:0] = rx_dat;
          cnt_d      = '0;
          state_d    = wr_q ? S_DATA : S_BUS;
        end
      end
      S_DATA: begin
        if (rx_fire) begin
          wdat_d = (wdat_q << 8) | WIDTH'(rx_dat);
          cnt_d  = cnt_q + 3'd1;
          if (cnt_q == NB_LAST) begin
            state_d = S_BUS;
          end
        end
      end
      S_BUS: begin
        // ack_i on the expiry cycle takes priority over the timeout
        if (ack_i) begin
          resp_d  = wr_q ? OK_WORD : dat_i;
          cnt_d   = wr_q ? 3'd1 : NB_CNT;
          state_d = S_RESP;
        end else if (tmo_expired) begin
          resp_d  = TMO_WORD;
          cnt_d   = 3'd1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (tx_fire) begin
          resp_d = resp_q << 8;
          cnt_d  = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial frame or bus cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      adr_q   <= '0;
      wdat_q  <= '0;
      resp_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      resp_q  <= resp_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_host_bridge.sv
// Directed self-checking bench for wb_host_bridge (WIDTH=32, TIMEOUT=8).
module tb_wb_host_bridge;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_dat;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_dat;
  logic        tx_valid;
  logic        tx_ready;
  logic [14:0] adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        we_o;
  logic        stb_o;
  logic        ack_i;

  int n_cmp = 0;
  int n_err = 0;

  wb_host_bridge #(
    .WIDTH   (32),
    .TIMEOUT (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_dat   (rx_dat),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_dat   (tx_dat),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .adr_o    (adr_o),
    .dat_o    (dat_o),
    .dat_i    (dat_i),
    .we_o     (we_o),
    .stb_o    (stb_o),
    .ack_i    (ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  // Present one byte and hold it until the bridge accepts it; returns 1ns after that edge
  task automatic send_byte(input logic [7:0] b);
    int w;
    rx_dat   = b;
    rx_valid = 1'b1;
    w = 0;
    while (!rx_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check("rx_accept", {31'd0, rx_ready}, 32'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  // Expect one response byte with tx_ready held high
  task automatic recv_byte(input logic [7:0] exp, input string tag);
    int w;
    tx_ready = 1'b1;
    w = 0;
    while (!tx_valid && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check({tag, "_valid"}, {31'd0, tx_valid}, 32'd1);
    check(tag, {24'd0, tx_dat}, {24'd0, exp});
    @(posedge clk); #1;
  endtask

  initial begin : stim
    logic [7:0] exp_bytes [4];
    logic [3:0] pat;
    int idx;
    int cyc;
    int stb_cnt;

    rst      = 1'b1;
    rx_dat   = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    dat_i    = 32'h0;
    ack_i    = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_dat", {24'd0, tx_dat}, 32'd0);
    check("rst_stb", {31'd0, stb_o}, 32'd0);
    check("rst_we", {31'd0, we_o}, 32'd0);
    check("rst_adr", {17'd0, adr_o}, 32'd0);
    check("rst_dat_o", dat_o, 32'd0);
    rst = 1'b0;
    #1;
    check("idle_rx_ready", {31'd0, rx_ready}, 32'd1);

    // Write with ack tied high: stb one cycle, 0xA5 the cycle after
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h18);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h12); send_byte(8'h34);
    check("wr_stb", {31'd0, stb_o}, 32'd1);
    check("wr_we", {31'd0, we_o}, 32'd1);
    check("wr_adr", {17'd0, adr_o}, 32'h0018);
    check("wr_dat", dat_o, 32'h0000_1234);
    check("wr_bus_rx_ready", {31'd0, rx_ready}, 32'd0);
    @(posedge clk); #1;
    check("wr_stb_drop", {31'd0, stb_o}, 32'd0);
    check("wr_tx_valid", {31'd0, tx_valid}, 32'd1);
    check("wr_tx_dat", {24'd0, tx_dat}, 32'h0000_00A5);
    @(posedge clk); #1;
    check("wr_done_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("wr_b2b_rx_ready", {31'd0, rx_ready}, 32'd1);

    // Read with 3 wait states; ADR_H bit 7 ignored
    ack_i = 1'b0;
    dat_i = 32'hDEAD_BEEF;
    send_byte(8'h02); send_byte(8'h80); send_byte(8'h10);
    check("rd_stb1", {31'd0, stb_o}, 32'd1);
    check("rd_we", {31'd0, we_o}, 32'd0);
    check("rd_adr", {17'd0, adr_o}, 32'h0010);
    @(posedge clk); #1;
    check("rd_stb2", {31'd0, stb_o}, 32'd1);
    @(posedge clk); #1;
    check("rd_stb3", {31'd0, stb_o}, 32'd1);
    @(posedge clk); #1;
    check("rd_stb4", {31'd0, stb_o}, 32'd1);
    check("rd_adr_stable", {17'd0, adr_o}, 32'h0010);
    ack_i = 1'b1;
    @(posedge clk); #1;
    ack_i = 1'b0;
    dat_i = 32'h0;
    check("rd_stb_drop", {31'd0, stb_o}, 32'd0);
    recv_byte(8'hDE, "rd_b0");
    recv_byte(8'hAD, "rd_b1");
    recv_byte(8'hBE, "rd_b2");
    recv_byte(8'hEF, "rd_b3");
    check("rd_done_tx_valid", {31'd0, tx_valid}, 32'd0);

    // Read under tx backpressure 1-0-0-1
    ack_i = 1'b1;
    dat_i = 32'h1122_3344;
    exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h22;
    exp_bytes[2] = 8'h33; exp_bytes[3] = 8'h44;
    pat = 4'b1001;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h08);
    @(posedge clk); #1;
    dat_i = 32'h0;
    idx = 0;
    cyc = 0;
    while (idx < 4 && cyc < 32) begin
      tx_ready = pat[3 - (cyc % 4)];
      check("bp_valid", {31'd0, tx_valid}, 32'd1);
      check("bp_dat", {24'd0, tx_dat}, {24'd0, exp_bytes[idx]});
      @(posedge clk); #1;
      if (tx_ready) idx++;
      cyc++;
    end
    tx_ready = 1'b1;
    check("bp_count", idx, 32'd4);
    check("bp_done_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("bp_rx_ready", {31'd0, rx_ready}, 32'd1);

    // Bad opcode swallowed, then a normal write
    send_byte(8'h7F);
    check("bad_no_tx", {31'd0, tx_valid}, 32'd0);
    check("bad_no_stb", {31'd0, stb_o}, 32'd0);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h20);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'hAB); send_byte(8'hCD);
    check("bad_wr_stb", {31'd0, stb_o}, 32'd1);
    check("bad_wr_adr", {17'd0, adr_o}, 32'h0020);
    check("bad_wr_dat", dat_o, 32'h0000_ABCD);
    recv_byte(8'hA5, "bad_wr_resp");
    check("bad_wr_single", {31'd0, tx_valid}, 32'd0);

`ifdef WB_TIMEOUT_EN
    // Timeout: no ack for TIMEOUT=8 cycles yields 0xEE
    ack_i = 1'b0;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h44);
    stb_cnt = 0;
    while (stb_o && stb_cnt < 40) begin
      stb_cnt++;
      @(posedge clk); #1;
    end
    check("tmo_stb_cycles", stb_cnt, 32'd8);
    recv_byte(8'hEE, "tmo_resp");
    check("tmo_single", {31'd0, tx_valid}, 32'd0);
    ack_i = 1'b1;
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h04);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    check("tmo_wr_dat", dat_o, 32'h0102_0304);
    recv_byte(8'hA5, "tmo_wr_resp");
`endif

    // Reset during a waiting bus cycle
    ack_i = 1'b0;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h04);
    stb_cnt = {31'd0, stb_o};
    @(posedge clk); #1;
    check("rstbus_stb_before", {31'd0, stb_o}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rstbus_stb", {31'd0, stb_o}, 32'd0);
    check("rstbus_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rstbus_rx_ready", {31'd0, rx_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    ack_i = 1'b1;
    #1;
    check("rstbus_idle", {31'd0, rx_ready}, 32'd1);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h30);
    send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hBA); send_byte(8'hBE);
    check("post_rst_adr", {17'd0, adr_o}, 32'h0030);
    check("post_rst_dat", dat_o, 32'hCAFE_BABE);
    check("post_rst_we", {31'd0, we_o}, 32'd1);
    recv_byte(8'hA5, "post_rst_resp");
    check("post_rst_done", {31'd0, tx_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
